// File: rtl/uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// uart_rx_cfg
//   Configurable oversampling UART receiver. The serial pin is synchronised,
//   each bit is sampled three times around its centre and majority voted.
//   Supports 5..9 data bits (LSB first), none/even/odd parity, 1 or 2 stop
//   bits, parity/framing error flags and line-break detection.
//
// Parameters
//   Oversample : clk cycles per bit (>= 8, even)
//   DataBits   : data bits per frame (5..9)
//   Parity     : 0 = none, 1 = even, 2 = odd
//   StopBits   : 1 or 2
//
// Ports
//   clk       in   clock
//   nReset    in   asynchronous active-low reset
//   in        in   serial line, asynchronous, idle high
//   data      out  last received word, updated only in the done cycle
//   done      out  1-cycle pulse, frame complete (also for error frames)
//   parityErr out  pulse with done: parity mismatch
//   frameErr  out  pulse with done: a stop bit voted 0 (or break)
//   breakDet  out  pulse with done: break condition
//   err       out  parityErr | frameErr
// ---------------------------------------------------------------------------
module uart_rx_cfg #(
  parameter int Oversample = 16,
  parameter int DataBits   = 8,
  parameter int Parity     = 0,
  parameter int StopBits   = 1
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic                in,
  output logic [DataBits-1:0] data,
  output logic                done,
  output logic                parityErr,
  output logic                frameErr,
  output logic                breakDet,
  output logic                err
);

  localparam int H  = Oversample / 2;
  localparam int P  = (Parity != 0) ? 1 : 0;
  localparam int N  = 1 + DataBits + P + StopBits;
  localparam int CW = $clog2(Oversample);
  localparam int BW = $clog2(N + 1);

  localparam logic [CW-1:0] OffEarly = CW'(H - 1);
  localparam logic [CW-1:0] OffMid   = CW'(H);
  localparam logic [CW-1:0] OffVote  = CW'(H + 1);
  localparam logic [CW-1:0] OffLast  = CW'(Oversample - 1);

  localparam logic [BW-1:0] LastData  = BW'(DataBits);
  localparam logic [BW-1:0] FirstStop = BW'(1 + DataBits + P);
  localparam logic [BW-1:0] LastStop  = BW'(N - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BRKWAIT
  } state_t;

  // Input path
  logic [1:0] sync_q;
  logic       s_in;
  logic       prev_q;

  // Frame state
  state_t              state_q,  state_d;
  logic [CW-1:0]       cnt_q,    cnt_d;     // offset within the current bit
  logic [BW-1:0]       bit_q,    bit_d;     // index of the current bit in the frame
  logic [1:0]          samp_q,   samp_d;    // samples at offsets h-1 and h
  logic [DataBits-1:0] shift_q,  shift_d;
  logic                allz_q,   allz_d;    // every vote so far was 0 (break candidate)
  logic                perr_q,   perr_d;
  logic                ferr_q,   ferr_d;

  // Registered outputs
  logic [DataBits-1:0] data_q, data_d;
  logic                done_q, done_d;
  logic                pe_q,   pe_d;
  logic                fe_q,   fe_d;
  logic                brk_q,  brk_d;
  logic                err_q,  err_d;

  logic vote;
  logic chk;
  logic ferr_now;

  assign s_in = sync_q[1];

  // Majority of the samples at h-1, h and the live sample at h+1.
  assign vote     = (samp_q[0] & samp_q[1]) | (samp_q[0] & s_in) | (samp_q[1] & s_in);
  assign chk      = (^shift_q) ^ vote;
  assign ferr_now = ferr_q | ~vote;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      samp_q  <= '0;
      shift_q <= '0;
      allz_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      brk_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], in};
      prev_q  <= s_in;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      samp_q  <= samp_d;
      shift_q <= shift_d;
      allz_q  <= allz_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      brk_q   <= brk_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case statement so no
    // path leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    samp_d  = samp_q;
    shift_d = shift_q;
    allz_d  = allz_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    pe_d    = 1'b0;
    fe_d    = 1'b0;
    brk_d   = 1'b0;

    // Inside a frame the sample counter free-runs from the start edge;
    // bit boundaries are never re-aligned to later edges.
    if (state_q != IDLE && state_q != BRKWAIT) begin
      if (cnt_q == OffLast) begin
        cnt_d = '0;
        bit_d = bit_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      if (cnt_q == OffEarly) samp_d[0] = s_in;
      if (cnt_q == OffMid)   samp_d[1] = s_in;
    end

    unique case (state_q)
      IDLE: begin
        // The edge cycle is offset 0 of the start bit.
        if (!s_in && prev_q) begin
          state_d = START;
          cnt_d   = CW'(1);
          bit_d   = '0;
          allz_d  = 1'b1;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end

      START: begin
        if (cnt_q == OffVote && vote) state_d = IDLE;   // false start
        else if (cnt_q == OffLast)    state_d = DATA;
      end

      DATA: begin
        if (cnt_q == OffVote) begin
          shift_d = {vote, shift_q[DataBits-1:1]};
          if (vote) allz_d = 1'b0;
        end
        if (cnt_q == OffLast && bit_q == LastData) state_d = (P != 0) ? PARITY : STOP;
      end

      PARITY: begin
        if (cnt_q == OffVote) begin
          perr_d = (Parity == 1) ? chk : ~chk;
          if (vote) allz_d = 1'b0;
        end
        if (cnt_q == OffLast) state_d = STOP;
      end

      STOP: begin
        if (cnt_q == OffVote) begin
          if (bit_q == FirstStop && allz_q && !vote) begin
            // Break: whole frame low through the first stop bit.
            done_d  = 1'b1;
            brk_d   = 1'b1;
            fe_d    = 1'b1;
            data_d  = '0;
            cnt_d   = '0;
            state_d = BRKWAIT;
          end else begin
            ferr_d = ferr_now;
            if (bit_q == LastStop) begin
              // Leave half a bit early so a start bit straight after the
              // stop bit is not missed.
              done_d  = 1'b1;
              pe_d    = perr_q;
              fe_d    = ferr_now;
              data_d  = shift_q;
              state_d = IDLE;
            end
          end
        end
      end

      BRKWAIT: begin
        // Wait for one full bit time of continuous idle before re-arming.
        if (!s_in)                 cnt_d   = '0;
        else if (cnt_q == OffLast) state_d = IDLE;
        else                       cnt_d   = cnt_q + 1'b1;
      end

      default: state_d = IDLE;
    endcase

    err_d = pe_d | fe_d;
  end

  assign data      = data_q;
  assign done      = done_q;
  assign parityErr = pe_q;
  assign frameErr  = fe_q;
  assign breakDet  = brk_q;
  assign err       = err_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_cfg
//   Directed bench for uart_rx_cfg. Five receivers share clock and reset:
//   0: 8N1, 1: 8E1, 2: 8N2, 3: 5O1, 4: 9N1 (all Oversample = 16).
//   Each receiver has its own serial line. A monitor logs every done pulse;
//   the scenario tasks compare the log against hand-computed values.
// ---------------------------------------------------------------------------
module tb_uart_rx_cfg;

  localparam int OS = 16;

  typedef struct {
    int         dut;
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       bd;
    logic       er;
    int         cyc;
  } ev_t;

  logic       clk;
  logic       nReset;
  logic [4:0] line;

  logic [7:0] d0, d1, d2;
  logic [4:0] d3;
  logic [8:0] d4;
  logic [4:0] done_w, pe_w, fe_w, bd_w, er_w;

  int   errors;
  int   checks;
  int   cyc;
  int   t_fall;
  ev_t  evq[$];

  uart_rx_cfg #(.Oversample(OS), .DataBits(8), .Parity(0), .StopBits(1)) u0 (
    .clk(clk), .nReset(nReset), .in(line[0]), .data(d0), .done(done_w[0]),
    .parityErr(pe_w[0]), .frameErr(fe_w[0]), .breakDet(bd_w[0]), .err(er_w[0]));
  uart_rx_cfg #(.Oversample(OS), .DataBits(8), .Parity(1), .StopBits(1)) u1 (
    .clk(clk), .nReset(nReset), .in(line[1]), .data(d1), .done(done_w[1]),
    .parityErr(pe_w[1]), .frameErr(fe_w[1]), .breakDet(bd_w[1]), .err(er_w[1]));
  uart_rx_cfg #(.Oversample(OS), .DataBits(8), .Parity(0), .StopBits(2)) u2 (
    .clk(clk), .nReset(nReset), .in(line[2]), .data(d2), .done(done_w[2]),
    .parityErr(pe_w[2]), .frameErr(fe_w[2]), .breakDet(bd_w[2]), .err(er_w[2]));
  uart_rx_cfg #(.Oversample(OS), .DataBits(5), .Parity(2), .StopBits(1)) u3 (
    .clk(clk), .nReset(nReset), .in(line[3]), .data(d3), .done(done_w[3]),
    .parityErr(pe_w[3]), .frameErr(fe_w[3]), .breakDet(bd_w[3]), .err(er_w[3]));
  uart_rx_cfg #(.Oversample(OS), .DataBits(9), .Parity(0), .StopBits(1)) u4 (
    .clk(clk), .nReset(nReset), .in(line[4]), .data(d4), .done(done_w[4]),
    .parityErr(pe_w[4]), .frameErr(fe_w[4]), .breakDet(bd_w[4]), .err(er_w[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [8:0] data_of(input int i);
    case (i)
      0:       data_of = {1'b0, d0};
      1:       data_of = {1'b0, d1};
      2:       data_of = {1'b0, d2};
      3:       data_of = {4'b0, d3};
      default: data_of = d4;
    endcase
  endfunction

  // Event log of done pulses, sampled on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (done_w[i] === 1'b1) begin
        ev_t e;
        e.dut  = i;
        e.data = data_of(i);
        e.pe   = pe_w[i];
        e.fe   = fe_w[i];
        e.bd   = bd_w[i];
        e.er   = er_w[i];
        e.cyc  = cyc;
        evq.push_back(e);
      end
    end
  end

  task automatic idle(input int di, input int n);
    repeat (n) begin
      @(negedge clk);
      line[di] = 1'b1;
    end
  endtask

  task automatic hold_low(input int di, input int n);
    repeat (n) begin
      @(negedge clk);
      line[di] = 1'b0;
    end
  endtask

  // Drive one frame; gbit/goff place a 1-cycle inversion, limit stops early.
  task automatic send(input int di, input logic [8:0] d, input int nb,
                      input bit has_par, input logic pbit, input logic s1,
                      input logic s2, input int ns, input int gbit,
                      input int goff, input int limit);
    logic fb[16];
    int   n;
    fb[0] = 1'b0;
    for (int i = 0; i < nb; i++) fb[1 + i] = d[i];
    n = 1 + nb;
    if (has_par) begin
      fb[n] = pbit;
      n = n + 1;
    end
    fb[n] = s1;
    n = n + 1;
    if (ns == 2) begin
      fb[n] = s2;
      n = n + 1;
    end
    for (int k = 0; k < n; k++) begin
      if (k >= limit) return;
      for (int o = 0; o < OS; o++) begin
        @(negedge clk);
        line[di] = (k == gbit && o == goff) ? ~fb[k] : fb[k];
        if (k == 0 && o == 0) t_fall = cyc;
      end
    end
  endtask

  task automatic test_reset;
    if (d0 !== 8'h00)     begin errors++; $display("FAIL reset_data got=%h exp=00", d0); end
    checks++;
    if (done_w !== 5'b0)  begin errors++; $display("FAIL reset_done got=%b exp=00000", done_w); end
    checks++;
    if (pe_w !== 5'b0 || fe_w !== 5'b0) begin
      errors++; $display("FAIL reset_pe_fe got=%b/%b exp=0/0", pe_w, fe_w);
    end
    checks++;
    if (bd_w !== 5'b0 || er_w !== 5'b0) begin
      errors++; $display("FAIL reset_bd_err got=%b/%b exp=0/0", bd_w, er_w);
    end
    checks++;
    if (d4 !== 9'h000)    begin errors++; $display("FAIL reset_data9 got=%h exp=000", d4); end
    checks++;
  endtask

  task automatic test_basic;
    evq.delete();
    send(0, 9'h0A5, 8, 0, 1'b0, 1'b1, 1'b1, 1, -1, 0, 99);
    idle(0, 2 * OS);
    if (evq.size() != 1) begin errors++; $display("FAIL basic_count got=%0d exp=1", evq.size()); end
    checks++;
    if (evq.size() >= 1) begin
      if (evq[0].data !== 9'h0A5) begin errors++; $display("FAIL basic_data got=%h exp=a5", evq[0].data); end
      checks++;
      if (evq[0].er !== 1'b0)     begin errors++; $display("FAIL basic_err got=%b exp=0", evq[0].er); end
      checks++;
      if (evq[0].cyc - t_fall != 2 + 9 * OS + 8 + 2) begin
        errors++; $display("FAIL basic_latency got=%0d exp=%0d", evq[0].cyc - t_fall, 2 + 9 * OS + 10);
      end
      checks++;
    end
  endtask

  task automatic test_parity;
    evq.delete();
    send(1, 9'h007, 8, 1, 1'b0, 1'b1, 1'b1, 1, -1, 0, 99);
    idle(1, 2 * OS);
    send(1, 9'h007, 8, 1, 1'b1, 1'b1, 1'b1, 1, -1, 0, 99);
    idle(1, 2 * OS);
    if (evq.size() != 2) begin errors++; $display("FAIL parity_count got=%0d exp=2", evq.size()); end
    checks++;
    if (evq.size() >= 2) begin
      if (evq[0].pe !== 1'b1 || evq[0].er !== 1'b1) begin
        errors++; $display("FAIL parity_bad_flags pe/err got=%b/%b exp=1/1", evq[0].pe, evq[0].er);
      end
      checks++;
      if (evq[0].data !== 9'h007) begin errors++; $display("FAIL parity_bad_data got=%h exp=07", evq[0].data); end
      checks++;
      if (evq[1].pe !== 1'b0 || evq[1].er !== 1'b0) begin
        errors++; $display("FAIL parity_good_flags pe/err got=%b/%b exp=0/0", evq[1].pe, evq[1].er);
      end
      checks++;
    end
  endtask

  task automatic test_stop2;
    evq.delete();
    send(2, 9'h05A, 8, 0, 1'b0, 1'b1, 1'b0, 2, -1, 0, 99);
    idle(2, 2 * OS);
    if (evq.size() != 1) begin errors++; $display("FAIL stop2_count got=%0d exp=1", evq.size()); end
    checks++;
    if (evq.size() >= 1) begin
      if (evq[0].fe !== 1'b1 || evq[0].er !== 1'b1) begin
        errors++; $display("FAIL stop2_flags fe/err got=%b/%b exp=1/1", evq[0].fe, evq[0].er);
      end
      checks++;
      if (evq[0].data !== 9'h05A) begin errors++; $display("FAIL stop2_data got=%h exp=5a", evq[0].data); end
      checks++;
    end
  endtask

  task automatic test_back_to_back;
    evq.delete();
    send(2, 9'h012, 8, 0, 1'b0, 1'b1, 1'b1, 2, -1, 0, 99);
    send(2, 9'h034, 8, 0, 1'b0, 1'b1, 1'b1, 2, -1, 0, 99);
    idle(2, 2 * OS);
    if (evq.size() != 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", evq.size()); end
    checks++;
    if (evq.size() >= 2) begin
      if (evq[0].data !== 9'h012 || evq[1].data !== 9'h034) begin
        errors++; $display("FAIL b2b_data got=%h,%h exp=12,34", evq[0].data, evq[1].data);
      end
      checks++;
      if (evq[0].er !== 1'b0 || evq[1].er !== 1'b0) begin
        errors++; $display("FAIL b2b_err got=%b,%b exp=0,0", evq[0].er, evq[1].er);
      end
      checks++;
    end
  endtask

  task automatic test_break;
    evq.delete();
    hold_low(0, 20 * OS);
    idle(0, OS);
    send(0, 9'h03C, 8, 0, 1'b0, 1'b1, 1'b1, 1, -1, 0, 99);
    idle(0, 2 * OS);
    if (evq.size() != 2) begin errors++; $display("FAIL break_count got=%0d exp=2", evq.size()); end
    checks++;
    if (evq.size() >= 2) begin
      if (evq[0].bd !== 1'b1 || evq[0].fe !== 1'b1) begin
        errors++; $display("FAIL break_flags bd/fe got=%b/%b exp=1/1", evq[0].bd, evq[0].fe);
      end
      checks++;
      if (evq[0].data !== 9'h000) begin errors++; $display("FAIL break_data got=%h exp=00", evq[0].data); end
      checks++;
      if (evq[1].data !== 9'h03C || evq[1].er !== 1'b0 || evq[1].bd !== 1'b0) begin
        errors++; $display("FAIL break_next got=%h err=%b bd=%b exp=3c 0 0", evq[1].data, evq[1].er, evq[1].bd);
      end
      checks++;
    end
  endtask

  task automatic test_glitch;
    evq.delete();
    hold_low(0, 4);
    idle(0, 3 * OS);
    if (evq.size() != 0) begin errors++; $display("FAIL glitch_idle_done got=%0d exp=0", evq.size()); end
    checks++;
    send(0, 9'h055, 8, 0, 1'b0, 1'b1, 1'b1, 1, -1, 0, 99);
    idle(0, 2 * OS);
    send(0, 9'h0A5, 8, 0, 1'b0, 1'b1, 1'b1, 1, 3, OS / 2, 99);
    idle(0, 2 * OS);
    if (evq.size() != 2) begin errors++; $display("FAIL glitch_count got=%0d exp=2", evq.size()); end
    checks++;
    if (evq.size() >= 2) begin
      if (evq[0].data !== 9'h055) begin errors++; $display("FAIL glitch_after_idle got=%h exp=55", evq[0].data); end
      checks++;
      if (evq[1].data !== 9'h0A5 || evq[1].er !== 1'b0) begin
        errors++; $display("FAIL glitch_data got=%h err=%b exp=a5 0", evq[1].data, evq[1].er);
      end
      checks++;
    end
  endtask

  task automatic test_midframe_reset;
    evq.delete();
    send(0, 9'h0FF, 8, 0, 1'b0, 1'b1, 1'b1, 1, -1, 0, 5);
    @(negedge clk);
    line[0] = 1'b1;
    nReset  = 1'b0;
    repeat (2) @(negedge clk);
    if (d0 !== 8'h00 || done_w[0] !== 1'b0 || er_w[0] !== 1'b0 || fe_w[0] !== 1'b0 ||
        pe_w[0] !== 1'b0 || bd_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs got data=%h done=%b err=%b exp all 0", d0, done_w[0], er_w[0]);
    end
    checks++;
    nReset = 1'b1;
    idle(0, 2 * OS);
    if (evq.size() != 0) begin errors++; $display("FAIL midreset_pulse got=%0d exp=0", evq.size()); end
    checks++;
    send(0, 9'h081, 8, 0, 1'b0, 1'b1, 1'b1, 1, -1, 0, 99);
    idle(0, 2 * OS);
    if (evq.size() != 1) begin errors++; $display("FAIL midreset_next_count got=%0d exp=1", evq.size()); end
    checks++;
    if (evq.size() >= 1) begin
      if (evq[0].data !== 9'h081) begin errors++; $display("FAIL midreset_next_data got=%h exp=81", evq[0].data); end
      checks++;
    end
  endtask

  task automatic test_widths;
    evq.delete();
    send(3, 9'h015, 5, 1, 1'b0, 1'b1, 1'b1, 1, -1, 0, 99);
    idle(3, 2 * OS);
    send(4, 9'h1AB, 9, 0, 1'b0, 1'b1, 1'b1, 1, -1, 0, 99);
    idle(4, 2 * OS);
    if (evq.size() != 2) begin errors++; $display("FAIL widths_count got=%0d exp=2", evq.size()); end
    checks++;
    if (evq.size() >= 2) begin
      if (evq[0].dut != 3 || evq[0].data !== 9'h015 || evq[0].er !== 1'b0) begin
        errors++; $display("FAIL width5o1 dut=%0d got=%h err=%b exp=15 0", evq[0].dut, evq[0].data, evq[0].er);
      end
      checks++;
      if (evq[1].dut != 4 || evq[1].data !== 9'h1AB || evq[1].er !== 1'b0) begin
        errors++; $display("FAIL width9n1 dut=%0d got=%h err=%b exp=1ab 0", evq[1].dut, evq[1].data, evq[1].er);
      end
      checks++;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    t_fall = 0;
    line   = 5'b11111;
    nReset = 1'b0;
    repeat (4) @(negedge clk);
    test_reset();
    nReset = 1'b1;
    repeat (4) @(negedge clk);
    test_basic();
    test_parity();
    test_stop2();
    test_back_to_back();
    test_break();
    test_glitch();
    test_midframe_reset();
    test_widths();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
